// File: rtl/ram_loader_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader_ctrl_pkg
// Description : Shared types and sizes for the RAM program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_loader_ctrl_pkg;

    localparam int RAM_DEPTH = 16;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_BYTE = 3'd1,
        S_LOAD_MAR  = 3'd2,
        S_WRITE     = 3'd3,
`ifdef RAM_LOADER_VERIFY_EN
        S_V_MAR     = 3'd4,
        S_V_READ    = 3'd5,
`endif
        S_DONE      = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_loader_checksum.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader_checksum
// Description : 8-bit modulo-256 accumulator with clear and add.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_loader_checksum
    import ram_loader_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_add,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_sum,
    output logic [DATA_W-1:0] o_sum_nxt
);

    logic [DATA_W-1:0] r_sum;

    // Sum including the current operand, so callers can compare on the final add.
    assign o_sum_nxt = r_sum + i_data;
    assign o_sum     = r_sum;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= o_sum_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader_ctrl
// Description : Loads a 16-byte program into RAM over a shared bus.
//               Define RAM_LOADER_VERIFY_EN for readback checksum verification.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_loader_ctrl
    import ram_loader_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] byte_data,
    output logic              byte_ready,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_drive,
    input  logic [DATA_W-1:0] ram_bus_in,
    output logic              load_mar_reg_n,
    output logic              prog_mode,
    output logic              control_signal,
    output logic              bus_enable_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] c_ADDR_LAST = ADDR_W'(RAM_DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_byte;
    logic              w_start;
    logic              w_hs;
    logic              w_addr_inc;
    logic [DATA_W-1:0] w_wr_sum;
    logic [DATA_W-1:0] w_unused_wr_nxt;

    assign w_start = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_hs    = (r_state == S_WAIT_BYTE) && byte_valid;
    assign addr    = r_addr;

`ifdef RAM_LOADER_VERIFY_EN
    // In verify mode the address wraps to 0 after the last write.
    assign w_addr_inc = (r_state == S_WRITE) ||
                        ((r_state == S_V_READ) && (r_addr != c_ADDR_LAST));
`else
    assign w_addr_inc = (r_state == S_WRITE) && (r_addr != c_ADDR_LAST);
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_nxt = S_WAIT_BYTE;
            end
            S_WAIT_BYTE: begin
                if (byte_valid) w_state_nxt = S_LOAD_MAR;
            end
            S_LOAD_MAR: w_state_nxt = S_WRITE;
            S_WRITE: begin
                if (r_addr != c_ADDR_LAST) begin
                    w_state_nxt = S_WAIT_BYTE;
                end else begin
`ifdef RAM_LOADER_VERIFY_EN
                    w_state_nxt = S_V_MAR;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef RAM_LOADER_VERIFY_EN
            S_V_MAR:  w_state_nxt = S_V_READ;
            S_V_READ: w_state_nxt = (r_addr == c_ADDR_LAST) ? S_DONE : S_V_MAR;
`endif
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_addr <= '0;
            r_byte <= '0;
        end else begin
            if (w_start) begin
                r_addr <= '0;
            end else if (w_addr_inc) begin
                r_addr <= r_addr + 1'b1;
            end
            if (w_hs) begin
                r_byte <= byte_data;
            end
        end
    end

    // Moore output decode; read enable and bus drive live in disjoint states.
    always_comb begin
        byte_ready     = 1'b0;
        bus_drive      = 1'b0;
        bus_out        = '0;
        load_mar_reg_n = 1'b1;
        control_signal = 1'b0;
        bus_enable_n   = 1'b1;
        prog_mode      = 1'b1;
        busy           = 1'b1;
        done           = 1'b0;
        case (r_state)
            S_IDLE: begin
                prog_mode = 1'b0;
                busy      = 1'b0;
            end
            S_DONE: begin
                prog_mode = 1'b0;
                busy      = 1'b0;
                done      = 1'b1;
            end
            S_WAIT_BYTE: byte_ready = 1'b1;
`ifdef RAM_LOADER_VERIFY_EN
            S_LOAD_MAR, S_V_MAR: begin
`else
            S_LOAD_MAR: begin
`endif
                bus_drive      = 1'b1;
                bus_out        = {{(DATA_W-ADDR_W){1'b0}}, r_addr};
                load_mar_reg_n = 1'b0;
            end
            S_WRITE: begin
                bus_drive      = 1'b1;
                bus_out        = r_byte;
                control_signal = 1'b1;
            end
`ifdef RAM_LOADER_VERIFY_EN
            S_V_READ: bus_enable_n = 1'b0;
`endif
            default: ;
        endcase
    end

    ram_loader_checksum u_wr_sum (
        .clk       (clk),
        .rst       (clr),
        .i_clear   (w_start),
        .i_add     (r_state == S_WRITE),
        .i_data    (r_byte),
        .o_sum     (w_wr_sum),
        .o_sum_nxt (w_unused_wr_nxt)
    );

`ifdef RAM_LOADER_VERIFY_EN
    logic [DATA_W-1:0] w_rd_sum_nxt;
    logic [DATA_W-1:0] w_unused_rd_sum;
    logic              r_error;

    ram_loader_checksum u_rd_sum (
        .clk       (clk),
        .rst       (clr),
        .i_clear   (w_start),
        .i_add     (r_state == S_V_READ),
        .i_data    (ram_bus_in),
        .o_sum     (w_unused_rd_sum),
        .o_sum_nxt (w_rd_sum_nxt)
    );

    always_ff @(posedge clk) begin
        if (clr || w_start) begin
            r_error <= 1'b0;
        end else if ((r_state == S_V_READ) && (r_addr == c_ADDR_LAST)) begin
            r_error <= (w_rd_sum_nxt != w_wr_sum);
        end
    end

    assign error = r_error;
`else
    logic w_unused_ok;
    assign w_unused_ok = ^{ram_bus_in, w_wr_sum};
    assign error       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_loader_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ram_loader_ctrl
// Description : Directed bench for ram_loader_ctrl with a behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_loader_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic [7:0] ram_bus_in;
    logic       byte_ready, bus_drive, load_mar_reg_n, prog_mode;
    logic       control_signal, bus_enable_n, busy, done, error;
    logic [7:0] bus_out;
    logic [3:0] addr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [16];
    logic [3:0] mar;
    bit         mem_init = 1'b1;
    bit         corrupt  = 1'b0;
    int         n_writes = 0, n_mar = 0, n_reads = 0, n_conflict = 0;
    int         w0, m0, r0;

`ifdef RAM_LOADER_VERIFY_EN
    localparam int EXP_READS = 16;
    localparam bit CORRUPT_ERR = 1'b1;
`else
    localparam int EXP_READS = 0;
    localparam bit CORRUPT_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    ram_loader_ctrl dut (
        .clk            (clk),
        .clr            (clr),
        .start          (start),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_ready     (byte_ready),
        .bus_out        (bus_out),
        .bus_drive      (bus_drive),
        .ram_bus_in     (ram_bus_in),
        .load_mar_reg_n (load_mar_reg_n),
        .prog_mode      (prog_mode),
        .control_signal (control_signal),
        .bus_enable_n   (bus_enable_n),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .addr           (addr)
    );

    // RAM with MAR; optional corruption of location 7 on readback.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 16; k++) mem[k] <= 8'hFF;
        end else if (control_signal) begin
            mem[mar] <= bus_out;
        end
        if (!load_mar_reg_n) begin
            mar   <= bus_out[3:0];
            n_mar <= n_mar + 1;
        end
        if (control_signal) n_writes <= n_writes + 1;
        if (!bus_enable_n)  n_reads  <= n_reads + 1;
        if (bus_drive && !bus_enable_n) n_conflict <= n_conflict + 1;
    end

    assign ram_bus_in = bus_enable_n ? 8'h00 :
                        ((corrupt && mar == 4'd7) ? (mem[mar] ^ 8'h80) : mem[mar]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_byte(input logic [7:0] d, input logic [3:0] a, input bit pulse_start);
        chk("wait_ready", byte_ready, 1);
        chk("wait_addr", addr, a);
        byte_data  = d;
        byte_valid = 1'b1;
        tick();
        byte_data = 8'hEE;
        chk("mar_ld_n", load_mar_reg_n, 0);
        chk("mar_bus", bus_out, {4'h0, a});
        chk("mar_ready", byte_ready, 0);
        if (pulse_start) start = 1'b1;
        tick();
        start = 1'b0;
        chk("wr_ctrl", control_signal, 1);
        chk("wr_bus", bus_out, d);
        chk("wr_busy", busy, 1);
        tick();
    endtask

    task automatic load_all(input logic [7:0] base, input int pulse_idx);
        w0 = n_writes; m0 = n_mar; r0 = n_reads;
        for (int i = 0; i < 16; i++)
            load_byte(8'(base + 8'(i)), 4'(i), i == pulse_idx);
        byte_valid = 1'b0;
    endtask

    task automatic finish_load(input logic [7:0] base, input logic exp_err);
        int bad;
`ifdef RAM_LOADER_VERIFY_EN
        chk("vmar_first_bus", bus_out, 0);
        chk("vmar_first_ld", load_mar_reg_n, 0);
        repeat (31) tick();
        chk("verify_not_early", done, 0);
        tick();
`endif
        chk("done", done, 1);
        chk("done_busy", busy, 0);
        chk("done_prog", prog_mode, 0);
        chk("done_addr", addr, 15);
        chk("done_error", error, exp_err);
        chk("write_count", n_writes - w0, 16);
        chk("read_count", n_reads - r0, EXP_READS);
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (mem[i] !== 8'(base + 8'(i))) bad++;
        chk("mem_contents", bad, 0);
    endtask

    initial begin
        int bad;
        // Reset state
        tick(); tick();
        mem_init = 1'b0;
        chk("rst_ready", byte_ready, 0);
        chk("rst_drive", bus_drive, 0);
        chk("rst_bus", bus_out, 0);
        chk("rst_mar_n", load_mar_reg_n, 1);
        chk("rst_ctrl", control_signal, 0);
        chk("rst_ben_n", bus_enable_n, 1);
        chk("rst_prog", prog_mode, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_addr", addr, 0);

        // Valid in IDLE is ignored
        clr = 1'b0;
        byte_valid = 1'b1;
        tick(); tick();
        chk("idle_valid_ready", byte_ready, 0);
        chk("idle_valid_busy", busy, 0);
        chk("idle_valid_writes", n_writes, 0);
        byte_valid = 1'b0;

        // Basic load 0x00..0x0F, valid held high
        start = 1'b1; tick(); start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_prog", prog_mode, 1);
        load_all(8'h00, -1);
        finish_load(8'h00, 1'b0);

        // Restart from DONE, stall 10 cycles, start pulse mid-load ignored
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_done", done, 0);
        chk("restart_addr", addr, 0);
        m0 = n_mar; w0 = n_writes;
        repeat (10) tick();
        chk("stall_ready", byte_ready, 1);
        chk("stall_addr", addr, 0);
        chk("stall_mar", n_mar - m0, 0);
        chk("stall_writes", n_writes - w0, 0);
        load_all(8'h30, 3);
        finish_load(8'h30, 1'b0);

        // Corrupted readback, then clean run clears error
        corrupt = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        load_all(8'h60, -1);
        finish_load(8'h60, CORRUPT_ERR);
        corrupt = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_err_clr", error, 0);
        load_all(8'h70, -1);
        finish_load(8'h70, 1'b0);

        // clr during WRITE of byte 5
        start = 1'b1; tick(); start = 1'b0;
        w0 = n_writes;
        for (int i = 0; i < 5; i++) load_byte(8'(8'hA0 + 8'(i)), 4'(i), 1'b0);
        byte_data = 8'hA5; byte_valid = 1'b1;
        tick(); tick();
        chk("abort_in_write", control_signal, 1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("abort_ready", byte_ready, 0);
        chk("abort_drive", bus_drive, 0);
        chk("abort_ctrl", control_signal, 0);
        chk("abort_mar_n", load_mar_reg_n, 1);
        chk("abort_busy", busy, 0);
        chk("abort_prog", prog_mode, 0);
        chk("abort_addr", addr, 0);
        repeat (5) tick();
        byte_valid = 1'b0;
        chk("abort_writes", n_writes - w0, 6);
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (mem[i] !== ((i <= 5) ? 8'(8'hA0 + 8'(i)) : 8'(8'h70 + 8'(i)))) bad++;
        chk("abort_mem", bad, 0);

        // clr overrides start on the same edge
        clr = 1'b1; start = 1'b1; tick(); clr = 1'b0; start = 1'b0;
        chk("clr_over_start", busy, 0);
        chk("bus_conflicts", n_conflict, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
